// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: holds the fetch PC, keeps one request in flight to
// instruction memory, buffers one instruction for decode and redirects on
// taken branches (from decode) or flushes (exception/mret).
module ysyx_22040127_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [63:0] if_to_id_bus,
  output logic        if_timer_int,
  input  logic        timer_int,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_result,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        preif_allowin
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, r_req_pc;
  logic        r_drop;
  logic        r_buf_valid, r_buf_int;
  logic [31:0] r_buf_inst, r_buf_pc;

  logic        w_in_wait, w_hs, w_resp, w_load;
  logic        w_redir_br, w_redir;
  logic [31:0] w_target;

  // Flush wins over a branch; a branch only counts when decode actually takes the bus.
  assign w_redir_br = id_branch_taken & id_allowin;
  assign w_redir    = flush | w_redir_br;
  assign w_target   = (flush ? flush_pc : id_branch_result) & 32'hFFFF_FFFC;

  assign w_in_wait  = (r_state == S_WAIT);
  // Only request when the response is guaranteed a buffer slot.
  assign imem_req_valid = !rst & !w_in_wait & (!r_buf_valid | id_allowin);
  assign imem_addr      = r_fetch_pc;
  assign w_hs           = imem_req_valid & imem_req_ready;
  assign preif_allowin  = w_hs;

  assign w_resp = w_in_wait & imem_resp_valid;
  // A response is kept only if no redirect has made it stale.
  assign w_load = w_resp & !r_drop & !w_redir;

  assign if_to_id_valid = r_buf_valid;
  assign if_to_id_bus   = {r_buf_inst, r_buf_pc};
  assign if_timer_int   = r_buf_int;

  // Next-state: leave REQ on handshake, leave WAIT on any response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_hs) w_state_nxt = S_WAIT;
      S_WAIT:  if (imem_resp_valid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  // Fetch PC advances on handshake; a redirect overrides the increment.
  always_ff @(posedge clk) begin
    if (rst)          r_fetch_pc <= RESET_PC;
    else if (w_redir) r_fetch_pc <= w_target;
    else if (w_hs)    r_fetch_pc <= r_fetch_pc + 32'd4;
  end

  // Remember the address of the request in flight.
  always_ff @(posedge clk) begin
    if (rst)       r_req_pc <= 32'h0;
    else if (w_hs) r_req_pc <= r_fetch_pc;
  end

  // Drop marks the in-flight response as stale after a redirect. If the
  // response lands in the redirect cycle it is discarded directly, so drop
  // must not be set then or the next good response would be lost.
  always_ff @(posedge clk) begin
    if (rst)
      r_drop <= 1'b0;
    else if (w_redir && ((w_in_wait && !imem_resp_valid) || w_hs))
      r_drop <= 1'b1;
    else if (w_resp)
      r_drop <= 1'b0;
  end

  // Output buffer valid: redirect clears, response fills, decode drains.
  always_ff @(posedge clk) begin
    if (rst)             r_buf_valid <= 1'b0;
    else if (w_redir)    r_buf_valid <= 1'b0;
    else if (w_load)     r_buf_valid <= 1'b1;
    else if (id_allowin) r_buf_valid <= 1'b0;
  end

  // Output buffer payload, loaded only by a kept response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_inst <= 32'h0;
      r_buf_pc   <= 32'h0;
      r_buf_int  <= 1'b0;
    end else if (w_load) begin
      r_buf_inst <= imem_resp_data;
      r_buf_pc   <= r_req_pc;
      r_buf_int  <= timer_int;
    end
  end

endmodule

// File: doc/ysyx_22040127_fetch.md
# ysyx_22040127_fetch

Instruction-fetch stage of the 5-stage RV64 pipeline. Sits between the instruction-memory port and the decode stage, and is the producer side of the `if_to_id` valid/allowin handshake. It holds the fetch PC, issues one-outstanding requests to instruction memory, buffers one fetched instruction for decode, and redirects on taken branches from decode or on exception/mret flush.

## Interface
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.

- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high, sampled on `posedge clk`
- `id_allowin`  in  1  decode can accept the bus this cycle
- `if_to_id_valid`  out  1  output buffer holds a valid instruction
- `if_to_id_bus`  out  64  {instruction[63:32], pc[31:0]}
- `if_timer_int`  out  1  timer-interrupt flag attached to the buffered instruction
- `timer_int`  in  1  timer interrupt pending
- `id_branch_taken`  in  1  instruction in ID is a taken branch/jal/jalr
- `id_branch_result`  in  32  branch target
- `flush`  in  1  exception/mret redirect
- `flush_pc`  in  32  flush target
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts the request
- `imem_addr`  out  32  request address, word-aligned
- `imem_resp_valid`  in  1  response data valid (always accepted)
- `imem_resp_data`  in  32  instruction word
- `preif_allowin`  out  1  request handshake completes this cycle (`imem_req_valid & imem_req_ready`)

## Operation
- State: FSM {REQ, WAIT}, `fetch_pc[31:0]`, `drop` flag, output buffer {`buf_valid`, `buf_inst`, `buf_pc`, `buf_int`}, in-flight `req_pc`.
- Redirect signals:
  - `redir_br = id_branch_taken & id_allowin`.
  - `redir = flush | redir_br`.
  - Target is `flush_pc` when `flush` is high, else `id_branch_result`. Flush has priority.
  - Target bits [1:0] are forced to 0.
- REQ:
  - `imem_req_valid = !buf_valid | id_allowin`, which guarantees buffer space for the response.
  - `imem_addr = fetch_pc`.
  - On handshake: `req_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`, go to WAIT.
- WAIT:
  - `imem_req_valid = 0`.
  - On `imem_resp_valid`: if `drop`, discard the data and clear `drop`. Otherwise load the buffer with {`imem_resp_data`, `req_pc`, `timer_int`} and set `buf_valid`. Go to REQ either way.
- Buffer drain: `buf_valid` clears when `buf_valid & id_allowin`, unless a response loads it in the same cycle.
- Redirect effects:
  - `fetch_pc <= target`, overriding the +4 update.
  - `buf_valid <= 0`. On a branch redirect decode itself drops anything transferred that cycle. A flush clears the buffer regardless of `id_allowin`.
  - If in WAIT, or if a REQ handshake completes in the same cycle, set `drop` so the in-flight response is discarded.
  - A response arriving in the same cycle as a redirect is discarded.
- Output mapping: `if_to_id_valid = buf_valid`, `if_to_id_bus = {buf_inst, buf_pc}`, `if_timer_int = buf_int`.

## Timing
- Reset values:
  - State REQ, `fetch_pc = RESET_PC`, `drop = 0`, `buf_valid = 0`, `buf_inst = 0`, `buf_pc = 0`, `buf_int = 0`.
  - Outputs: `if_to_id_valid = 0`, `if_to_id_bus = 0`, `if_timer_int = 0`.
  - `imem_req_valid = 0` during the reset cycle and 1 in the first cycle after reset.
- Reset mid-WAIT: the outstanding response is lost and `drop` clears. The bench must not return a response for the pre-reset request.
- Latency: request accepted in cycle t, response in t+k, `if_to_id_valid` high in t+k+1. The next request can issue in t+k+1 if `id_allowin`.
  - With k=1, steady-state throughput is 1 instruction per 2 cycles.
- Only one request is outstanding. No new request issues while in WAIT.
- `imem_req_valid` may drop without a handshake when the buffer becomes full-and-stalled or on a redirect. Address changes without a handshake are permitted only on a redirect.
- Backpressure: the buffer holds its contents stable while `!id_allowin`.
- PC wrap: `32'hFFFF_FFFC + 4 = 0`. No trap.

## Test plan
- Reset, then a 1-cycle memory returning `inst = pc ^ 32'h13` -> buses carry pc `0x80000000`, `0x80000004`, `0x80000008` on cycles 3, 5, 7, with `if_to_id_valid` low otherwise.
- `id_allowin = 0` for 4 cycles while the buffer holds pc `0x80000004` -> bus stable, `imem_req_valid = 0`, no extra requests. Release -> next request addresses `0x80000008`.
- Response latency 3 with `id_branch_taken = 1` and target `0x80001000` during WAIT -> stale response discarded, next `imem_addr = 0x80001000`, next valid bus pc `0x80001000`.
- `flush = 1` (`flush_pc = 0x80000100`) and `id_branch_taken = 1` (target `0x80002000`) in the same cycle -> next request `0x80000100`, buffer cleared.
- `imem_req_ready` held low 5 cycles -> `imem_req_valid` high with a constant address, `preif_allowin = 0`. Ready high -> `preif_allowin = 1` for exactly one cycle.
- `rst` asserted while in WAIT -> next cycle all outputs at reset values. First post-reset request to `RESET_PC`, and no bus value from before reset appears.
